// File: rtl/add_serial_digit_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
// Combinational helpers only; no latency.
// No flow control lives here.
package add_serial_digit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width: clog2(n/2), never less than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/add_rca_2_bit.sv
// Two-bit ripple-carry adder slice: s = a + b + ci.
// Purely combinational, zero cycles.
// No backpressure; the caller registers inputs and outputs.
module add_rca_2_bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic c1;

  // Two full adders chained through c1.
  always_comb begin
    s[0] = a[0] ^ b[0] ^ ci;
    c1   = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    s[1] = a[1] ^ b[1] ^ c1;
    co   = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  end

endmodule

// File: rtl/add_serial_digit.sv
// Digit-serial N-bit adder, two bits per clock through one add_rca_2_bit slice.
// Latency N/2 cycles from the accepting edge to done; one add per N/2+1 cycles.
// start is ignored while busy; optional ovf output when ADD_SERIAL_OVF_EN is defined.
module add_serial_digit
  import add_serial_digit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         co
`ifdef ADD_SERIAL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);

  state_t         state;
  logic [N-1:0]   x_sh;
  logic [N-1:0]   y_sh;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [1:0]     slice_s;
  logic           slice_co;
  logic [N+1:0]   sum_cat;

`ifdef ADD_SERIAL_OVF_EN
  logic           x_msb;
  logic           y_msb;
`endif

  add_rca_2_bit u_slice (
    .a  (x_sh[1:0]),
    .b  (y_sh[1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // New digit enters sum from the MSB end; concatenation keeps N=2 legal.
  always_comb begin
    sum_cat = {slice_s, sum};
  end

  // FSM, operand shift registers, carry register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_sh  <= '0;
      y_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            x_sh  <= X;
            y_sh  <= Y;
            carry <= ci;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef ADD_SERIAL_OVF_EN
            x_msb <= X[N-1];
            y_msb <= Y[N-1];
`endif
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum   <= sum_cat[N+1:2];
          carry <= slice_co;
          x_sh  <= x_sh >> 2;
          y_sh  <= y_sh >> 2;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            co    <= slice_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef ADD_SERIAL_OVF_EN
            // slice_s[1] is the final sum MSB on this edge.
            ovf   <= x_msb ^ y_msb ^ slice_s[1] ^ slice_co;
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_digit.sv
// Directed bench for add_serial_digit at N=8 with hand-computed results.
// Samples outputs 1 ns after each rising edge.
// Exercises reset, latency, back-to-back starts, ignored starts and mid-run reset.
module tb_add_serial_digit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] X;
  logic [7:0] Y;
  logic       ci;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       co;
`ifdef ADD_SERIAL_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  add_serial_digit #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
`ifdef ADD_SERIAL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until done (bounded); returns the number of edges taken.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic do_add(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic [7:0] es, input logic eco);
    int cyc;
    X = x; Y = y; ci = c; start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_e0"}, busy, 1);
    wait_done(cyc);
    chk({tag, "_lat"}, cyc, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_co"}, co, eco);
    chk({tag, "_busy_done"}, busy, 0);
    step();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_sum_hold"}, sum, es);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int extra;
    rst_n = 1'b0; start = 1'b0; X = '0; Y = '0; ci = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", co, 0);
    rst_n = 1'b1;
    step();

    // FF + 01: busy counted edge by edge
    X = 8'hFF; Y = 8'h01; ci = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      cyc++;
    end
    chk("t1_lat", cyc, 4);
    chk("t1_busy_cycles", busy_cnt, 4);
    chk("t1_sum", sum, 8'h00);
    chk("t1_co", co, 1);
    step();

    // 3C + 5A + 1, start held so the next add is accepted in DONE
    X = 8'h3C; Y = 8'h5A; ci = 1'b1; start = 1'b1;
    step();
    X = 8'h80; Y = 8'h80; ci = 1'b0;
    wait_done(cyc);
    chk("t2_lat", cyc, 4);
    chk("t2_sum", sum, 8'h97);
    chk("t2_co", co, 0);
    cyc = 0;
    step();
    cyc++;
    start = 1'b0;
    chk("t2_b2b_busy", busy, 1);
    chk("t2_b2b_done", done, 0);
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t2_b2b_gap", cyc, 5);
    chk("t2_b2b_sum", sum, 8'h00);
    chk("t2_b2b_co", co, 1);
    step();

    // start pulsed mid-run with other operands must be ignored
    X = 8'h12; Y = 8'h34; ci = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    X = 8'hFF; Y = 8'hFF; ci = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 3 - 1;
    while (done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t3_lat", cyc, 4);
    chk("t3_sum", sum, 8'h46);
    chk("t3_co", co, 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    chk("t3_no_extra", extra, 0);
    chk("t3_sum_hold", sum, 8'h46);

    // reset during the second RUN cycle
    X = 8'hFF; Y = 8'hFF; ci = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_sum", sum, 0);
    chk("t4_rst_co", co, 0);
    step();
    rst_n = 1'b1;
    step();
    do_add("t4_post", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    do_add("t5", 8'hA5, 8'h5B, 1'b1, 8'h01, 1'b1);

`ifdef ADD_SERIAL_OVF_EN
    do_add("ovf1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    chk("ovf1_ovf", ovf, 1);
    do_add("ovf2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    chk("ovf2_ovf", ovf, 0);
    do_add("ovf3", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1);
    chk("ovf3_ovf", ovf, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
